// File: rtl/unum4_multiply_if.sv
// Operand/result bundle for the unum4 multiplier: start strobe plus operands in,
// busy/done handshake plus normalized product and flags out.
interface unum4_multiply_if #(
  parameter int MAN_MAX_W = 29,
  parameter int EXP_MAX_W = 16
);
  logic                 start;
  logic [MAN_MAX_W-1:0] m_a;
  logic [MAN_MAX_W-1:0] m_b;
  logic [EXP_MAX_W-1:0] e_a;
  logic [EXP_MAX_W-1:0] e_b;
  logic                 busy;
  logic                 done;
  logic [MAN_MAX_W-1:0] m_o;
  logic [EXP_MAX_W-1:0] e_o;
  logic                 over;
  logic                 under;
  logic                 zero;

  modport master (
    output start, m_a, m_b, e_a, e_b,
    input  busy, done, m_o, e_o, over, under, zero
  );

  modport slave (
    input  start, m_a, m_b, e_a, e_b,
    output busy, done, m_o, e_o, over, under, zero
  );
endinterface

// File: rtl/unum4_multiply.sv
// Radix-2 shift-add mantissa/exponent multiplier; fixed W+2 edges from accept to done.
// start is only sampled in IDLE, so requests during an operation are dropped.
module unum4_multiply #(
  parameter int MAN_MAX_W = 29,
  parameter int EXP_MAX_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  unum4_multiply_if.slave     bus
);
  localparam int W  = MAN_MAX_W;
  localparam int E  = EXP_MAX_W;
  localparam int XW = E + 2;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);
  localparam int KW = $clog2(PW + 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << (E - 1)) - 1);
  localparam logic signed [XW-1:0] EMIN = ~EMAX;

  typedef enum logic [1:0] {IDLE, MUL, NORM, OUT} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  zero_op_q, zero_op_d;
  logic [PW-1:0]         mcand_q, mcand_d;
  logic [W-1:0]          mplier_q, mplier_d;
  logic [PW-1:0]         p_q, p_d;
  logic [CW-1:0]         count_q, count_d;
  logic signed [XW-1:0]  esum_q, esum_d;
  logic [W-1:0]          m_n_q, m_n_d;
  logic signed [XW-1:0]  e_n_q, e_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [W-1:0]          m_o_q, m_o_d;
  logic [E-1:0]          e_o_q, e_o_d;
  logic                  over_q, over_d;
  logic                  under_q, under_d;
  logic                  zero_q, zero_d;

  logic [W-1:0]          a_abs, b_abs;
  logic [KW-1:0]         lz;
  logic [W-2:0]          mag;
  logic signed [XW-1:0]  e_calc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      zero_op_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      p_q       <= '0;
      count_q   <= '0;
      esum_q    <= '0;
      m_n_q     <= '0;
      e_n_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_o_q     <= '0;
      e_o_q     <= '0;
      over_q    <= 1'b0;
      under_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      zero_op_q <= zero_op_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      p_q       <= p_d;
      count_q   <= count_d;
      esum_q    <= esum_d;
      m_n_q     <= m_n_d;
      e_n_q     <= e_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_o_q     <= m_o_d;
      e_o_q     <= e_o_d;
      over_q    <= over_d;
      under_q   <= under_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    a_abs = bus.m_a[W-1] ? (~bus.m_a + W'(1)) : bus.m_a;
    b_abs = bus.m_b[W-1] ? (~bus.m_b + W'(1)) : bus.m_b;

    // Highest set bit wins, giving the leading-zero count of the product.
    lz = KW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (p_q[i]) lz = KW'(PW - 1 - i);
    end
    mag    = (W-1)'((p_q << lz) >> (W + 1));
    e_calc = esum_q + XW'(2) - XW'(lz);
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    zero_op_d = zero_op_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    p_d       = p_q;
    count_d   = count_q;
    esum_d    = esum_q;
    m_n_d     = m_n_q;
    e_n_d     = e_n_q;
    busy_d    = (state_q == MUL) || (state_q == NORM);
    done_d    = 1'b0;
    m_o_d     = m_o_q;
    e_o_d     = e_o_q;
    over_d    = over_q;
    under_d   = under_q;
    zero_d    = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = MUL;
          sign_d    = bus.m_a[W-1] ^ bus.m_b[W-1];
          zero_op_d = (bus.m_a == '0) || (bus.m_b == '0);
          mcand_d   = {{W{1'b0}}, a_abs};
          mplier_d  = b_abs;
          p_d       = '0;
          count_d   = CW'(W);
          esum_d    = $signed({{2{bus.e_a[E-1]}}, bus.e_a}) + $signed({{2{bus.e_b[E-1]}}, bus.e_b});
        end
      end
      MUL: begin
        if (mplier_q[0]) p_d = p_q + mcand_q;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = NORM;
      end
      NORM: begin
        state_d = OUT;
        e_n_d   = e_calc;
        // -0.5 in magnitude form is re-expressed as -1.0 so negatives stay canonical.
        if (sign_q && (mag == {1'b1, {(W-2){1'b0}}})) begin
          m_n_d = {1'b1, {(W-1){1'b0}}};
          e_n_d = e_calc - XW'(1);
        end else if (sign_q) begin
          m_n_d = W'(0) - {1'b0, mag};
        end else begin
          m_n_d = {1'b0, mag};
        end
      end
      OUT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        m_o_d   = '0;
        e_o_d   = '0;
        over_d  = 1'b0;
        under_d = 1'b0;
        zero_d  = 1'b0;
        if (zero_op_q) begin
          zero_d = 1'b1;
        end else if (e_n_q > EMAX) begin
          over_d = 1'b1;
        end else if (e_n_q < EMIN) begin
          under_d = 1'b1;
        end else begin
          m_o_d = m_n_q;
          e_o_d = e_n_q[E-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.m_o   = m_o_q;
  assign bus.e_o   = e_o_q;
  assign bus.over  = over_q;
  assign bus.under = under_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_unum4_multiply.sv
// Randomized and directed checks of unum4_multiply against a value-level reference model.
module tb_unum4_multiply;
  localparam int W = 8;
  localparam int E = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  unum4_multiply_if #(.MAN_MAX_W(W), .EXP_MAX_W(E)) bus ();

  unum4_multiply #(.MAN_MAX_W(W), .EXP_MAX_W(E)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Product value = (a*b)/2^(2W-2) * 2^(ea+eb); re-expressed as mag/2^(W-1) * 2^e
  // with mag in [2^(W-2), 2^(W-1)).
  function automatic void ref_mul(input logic [W-1:0] ma, mb, input logic [E-1:0] ea, eb,
                                  output logic [W-1:0] m, output logic [E-1:0] e,
                                  output logic ov, output logic un, output logic z);
    int a, b, p, absp, es, top, mag, ei, mv;
    a  = int'($signed(ma));
    b  = int'($signed(mb));
    es = int'($signed(ea)) + int'($signed(eb));
    p  = a * b;
    m = '0; e = '0; ov = 1'b0; un = 1'b0; z = 1'b0;
    if (p == 0) begin
      z = 1'b1;
      return;
    end
    absp = (p < 0) ? -p : p;
    top  = 0;
    for (int i = 0; i < 31; i++) if (((absp >> i) & 1) == 1) top = i;
    mag = (top >= W - 2) ? (absp >> (top - (W - 2))) : (absp << ((W - 2) - top));
    ei  = es - (2 * W - 2) + 1 + top;
    if (p < 0 && mag == (1 << (W - 2))) begin
      mv = -(1 << (W - 1));
      ei = ei - 1;
    end else begin
      mv = (p < 0) ? -mag : mag;
    end
    if (ei > (1 << (E - 1)) - 1) ov = 1'b1;
    else if (ei < -(1 << (E - 1))) un = 1'b1;
    else begin
      m = W'(mv);
      e = E'(ei);
    end
  endfunction

  // Entered and left #1 after a posedge. Returns the edge index of done (0 on timeout).
  task automatic run_op(input logic [W-1:0] ma, mb, input logic [E-1:0] ea, eb,
                        input bit pulse_mid, output int lat, output int busy_cnt);
    bus.m_a = ma; bus.m_b = mb; bus.e_a = ea; bus.e_b = eb;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.m_a = W'($urandom); bus.m_b = W'($urandom);
    bus.e_a = E'($urandom); bus.e_b = E'($urandom);
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      bus.start = (pulse_mid && i == 3);
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) lat = i;
    end
    bus.start = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] ma, mb,
                          input logic [E-1:0] ea, eb, input bit pulse_mid);
    logic [W-1:0] m; logic [E-1:0] e; logic ov, un, z;
    int lat, bc, extra;
    ref_mul(ma, mb, ea, eb, m, e, ov, un, z);
    run_op(ma, mb, ea, eb, pulse_mid, lat, bc);
    chk({tag, " latency"}, lat, W + 2);
    chk({tag, " busy_cycles"}, bc, W + 1);
    chk({tag, " m_o"}, bus.m_o, m);
    chk({tag, " e_o"}, bus.e_o, e);
    chk({tag, " flags"}, {bus.over, bus.under, bus.zero}, {ov, un, z});
    if (pulse_mid) begin
      extra = 0;
      for (int i = 0; i < 14; i++) begin
        @(posedge clk); #1;
        if (bus.done) extra++;
      end
      chk({tag, " extra_done"}, extra, 0);
    end
  endtask

  initial begin
    int lat, bc, dn;
    logic [W-1:0] ra, rb;
    logic [E-1:0] rea, reb;
    bus.start = 1'b0; bus.m_a = '0; bus.m_b = '0; bus.e_a = '0; bus.e_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {bus.busy, bus.done, bus.over, bus.under, bus.zero}, 5'b0);
    chk("reset m_o", bus.m_o, 0);
    chk("reset e_o", bus.e_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    op_check("half_sq", 8'h40, 8'h40, 8'h00, 8'h00, 1'b0);
    chk("half_sq lit_m", bus.m_o, 8'h40);
    chk("half_sq lit_e", bus.e_o, 8'hFF);
    op_check("neg1_sq", 8'h80, 8'h80, 8'h00, 8'h00, 1'b0);
    chk("neg1_sq lit", {bus.m_o, bus.e_o}, 16'h4001);
    op_check("canon_neg", 8'h40, 8'hC0, 8'h00, 8'h00, 1'b0);
    chk("canon_neg lit", {bus.m_o, bus.e_o}, 16'h80FE);
    op_check("ovf", 8'h40, 8'h40, 8'h7F, 8'h7F, 1'b0);
    chk("ovf lit", {bus.over, bus.under, bus.m_o, bus.e_o}, {2'b10, 16'h0000});
    op_check("unf", 8'h40, 8'h40, 8'h80, 8'h80, 1'b0);
    chk("unf lit", {bus.over, bus.under}, 2'b01);
    op_check("zero_op", 8'h00, 8'h55, 8'h12, 8'h34, 1'b1);
    chk("zero_op lit", bus.zero, 1'b1);

    // Leave a nonzero result so the abort visibly clears outputs.
    op_check("pre_abort", 8'h60, 8'h50, 8'h03, 8'h01, 1'b0);
    bus.m_a = 8'h70; bus.m_b = 8'h90; bus.e_a = 8'h02; bus.e_b = 8'h01;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort outs", {bus.busy, bus.done, bus.over, bus.under, bus.zero}, 5'b0);
    chk("abort m_e", {bus.m_o, bus.e_o}, 16'h0000);
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk("abort no_done", dn, 0);
    op_check("post_abort", 8'h70, 8'h90, 8'h02, 8'h01, 1'b0);

    // Back-to-back: start issued in the done cycle must be accepted.
    run_op(8'h33, 8'hA5, 8'h05, 8'hFB, 1'b0, lat, bc);
    op_check("back2back", 8'hC7, 8'h19, 8'h10, 8'hF0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (n % 9 == 0) ra = 8'h80;
      if (n % 11 == 5) rb = 8'h00;
      if (n % 2 == 0) begin
        rea = E'($urandom_range(0, 40)) - 8'd20;
        reb = E'($urandom_range(0, 40)) - 8'd20;
      end else begin
        rea = E'($urandom);
        reb = E'($urandom);
      end
      op_check("rand", ra, rb, rea, reb, (n % 7) == 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unum4_multiply.md
Name: unum4_multiply

Overview:
- Iterative (radix-2 shift-add) mantissa/exponent multiplier for the unum4 arithmetic datapath. It is the multiplicative counterpart to the serial division unit.
- Takes two signed two's-complement mantissas and two signed exponents, and produces a normalized product mantissa/exponent pair with over/under/zero flags.
- Uses a start/done handshake with fixed latency. Sits beside the divide unit in the unum4 FPU core.

Parameters:
- MAN_MAX_W, 29, mantissa width. Signed Q1.(W-1) fraction: value = m/2^(W-1).
- EXP_MAX_W, 16, signed exponent width. Operand value = mantissa × 2^e.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  operand-valid strobe; sampled only in IDLE
- m_a  in  MAN_MAX_W  mantissa A, signed
- m_b  in  MAN_MAX_W  mantissa B, signed
- e_a  in  EXP_MAX_W  exponent A, signed
- e_b  in  EXP_MAX_W  exponent B, signed
- busy  out  1  high from the edge after start is accepted until done
- done  out  1  one-cycle result-valid pulse
- m_o  out  MAN_MAX_W  normalized product mantissa, signed
- e_o  out  EXP_MAX_W  product exponent, signed
- over  out  1  exponent overflow
- under  out  1  exponent underflow
- zero  out  1  either operand mantissa is zero

Behaviour:
- Reset: state IDLE. busy=0, done=0, m_o=0, e_o=0, over=0, under=0, zero=0. The iteration counter and accumulator are cleared.
- FSM states: IDLE → MUL → NORM → OUT → IDLE.
- IDLE, start=1 at edge t:
  - Register sign = m_a[W-1]^m_b[W-1].
  - Register |m_a|, |m_b| as W-bit unsigned (|-1.0| = 2^(W-1) is representable).
  - Register esum = e_a+e_b, sign-extended to EXP_MAX_W+2 bits.
  - Register zero_op = (m_a==0)|(m_b==0).
  - Clear the 2W-bit accumulator P; set count=W.
- MUL: each cycle, if the multiplier LSB is 1 then add the shifted multiplicand into P. Shift the multiplier right and the multiplicand left; decrement count. Exit to NORM after W cycles (edges t+1..t+W).
- NORM (edge t+W+1), registered:
  - k = leading-zero count of P (2W bits).
  - mag = (P<<k)[2W-1:W+1], which is W-1 bits, truncated toward zero.
  - e_n = esum + 2 - k.
  - If sign: m_n = -{0,mag}. Special case: if mag == 2^(W-2) exactly, m_n = 100…0 (−1.0) and e_n = e_n-1, so negatives stay in canonical normalized form (m[W-1] != m[W-2]).
  - If not sign: m_n = {0,mag}.
- OUT (edge t+W+2): register outputs and assert done for one cycle. Priority:
  1. zero_op: m_o=0, e_o=0, zero=1, over=0, under=0.
  2. e_n > 2^(E-1)-1: over=1, m_o=0, e_o=0.
  3. e_n < -2^(E-1): under=1, m_o=0, e_o=0.
  4. Otherwise: m_o=m_n, e_o=e_n[E-1:0], flags 0.
- Latency: fixed. done is high in the cycle following edge t+W+2, regardless of operand values (zero operands still iterate).
- Outputs and flags hold until the next OUT. Flags are re-evaluated every result and are not sticky.
- start while busy (MUL/NORM/OUT) is ignored; no queuing. start in the done cycle (state IDLE again) is accepted.
- Operand inputs need only be stable at the accepting edge.
- rst mid-operation aborts to IDLE with reset values. No done is issued for the aborted operation.
- Exponent arithmetic is carried at EXP_MAX_W+2 bits signed; no intermediate wrap.

Test Plan (MAN_MAX_W=8, EXP_MAX_W=8):
- m_a=0x40, m_b=0x40, e_a=0, e_b=0, start → done exactly 10 cycles later; m_o=0x40, e_o=0xFF (0.25); flags 0; busy high for 9 cycles.
- m_a=0x80, m_b=0x80, e=0,0 (−1×−1) → m_o=0x40, e_o=0x01.
- m_a=0x40, m_b=0xC0, e=0,0 (0.5×−0.5) → canonical negative: m_o=0x80, e_o=0xFE.
- m_a=0x40, m_b=0x40, e_a=0x7F, e_b=0x7F → over=1, m_o=0, e_o=0. Then e_a=0x80, e_b=0x80 → under=1, over=0.
- m_a=0x00, m_b=0x55 → zero=1, m_o=0, e_o=0, still after 10 cycles. Second start pulsed during MUL is ignored: exactly one done.
- Start an operation, assert rst at cycle 4 → busy=0 and all outputs 0 next cycle, no done. A new start after reset completes normally.
